// File: rtl/fc_dlmon_pkg.sv
// rtl/fc_dlmon_pkg.sv - shared types, widths and helpers for the deadlock watchdog
package fc_dlmon_pkg;

    localparam int CYC_W = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DEADLOCK = 2'd2
    } dlmon_state_t;

    // Lowest set bit index of a vector up to 32 bits wide; 0 when empty.
    function automatic logic [4:0] lowest_set_bit(input logic [31:0] v);
        lowest_set_bit = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set_bit = 5'(i);
        end
    endfunction

endpackage

// File: rtl/fc_dlmon_prio_enc.sv
// rtl/fc_dlmon_prio_enc.sv - combinational lowest-set-bit encoder with valid flag
module fc_dlmon_prio_enc
    import fc_dlmon_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [31:0] data_ext;

    always_comb begin
        data_ext               = '0;
        data_ext[WIDTH-1:0]    = data_i;
        idx_o                  = IDX_W'(lowest_set_bit(data_ext));
        valid_o                = |data_i;
    end

endmodule

// File: rtl/fc_deadlock_watchdog.sv
// rtl/fc_deadlock_watchdog.sv - flags a kernel deadlock when one stall pattern persists THRESH cycles
module fc_deadlock_watchdog
    import fc_dlmon_pkg::*;
#(
    parameter int AXIS_N = 8,
    parameter int INST_N = 5,
    parameter int BLK_N  = 1,
    parameter int THRESH = 1024,
    localparam int ID_W  = (AXIS_N > 1) ? $clog2(AXIS_N) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [AXIS_N-1:0] axis_block_sigs,
    input  logic [INST_N-1:0] inst_idle_sigs,
    input  logic [BLK_N-1:0]  inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic [AXIS_N-1:0] block_axis_snap,
    output logic [ID_W-1:0]   block_first_id,
    output logic [CYC_W-1:0]  block_cycles,
    output logic [1:0]        state_o
);

    localparam int CNT_W = $clog2(THRESH + 1);
    localparam int PAT_W = AXIS_N + BLK_N;

    dlmon_state_t      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [PAT_W-1:0]  prev_q, pattern;
    logic [CYC_W-1:0]  cyc_q;
    logic              block_q;
    logic [AXIS_N-1:0] snap_q;
    logic [ID_W-1:0]   first_id_q;
    logic [CYC_W-1:0]  stamp_q;
    logic              stall_now;
    logic              detect;
    logic [ID_W-1:0]   enc_idx;
    logic              enc_valid;

    // A fully idle kernel is quiescent, not deadlocked.
    assign stall_now = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
    assign pattern   = {inst_block_sigs, axis_block_sigs};
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    fc_dlmon_prio_enc #(
        .WIDTH (AXIS_N)
    ) u_prio_enc (
        .data_i  (axis_block_sigs),
        .idx_o   (enc_idx),
        .valid_o (enc_valid)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clear overrides every transition, including the detection edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        detect  = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stall_now) begin
                        state_d = WATCH;
                        cnt_d   = CNT_W'(1);
                    end
                end
                WATCH: begin
                    if (!stall_now) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (pattern != prev_q) begin
                        cnt_d = CNT_W'(1);
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_W'(THRESH)) begin
                            state_d = DEADLOCK;
                            detect  = 1'b1;
                        end
                    end
                end
                DEADLOCK: ;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        state_o         = state_q;
        block           = block_q;
        block_axis_snap = snap_q;
        block_first_id  = first_id_q;
        block_cycles    = stamp_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_q     <= '0;
            cyc_q      <= '0;
            block_q    <= 1'b0;
            snap_q     <= '0;
            first_id_q <= '0;
            stamp_q    <= '0;
        end else begin
            prev_q <= pattern;
            cyc_q  <= cyc_q + CYC_W'(1);
            // Snapshots survive clear so the bench can still report them.
            if (clear) begin
                block_q <= 1'b0;
            end else if (detect) begin
                block_q    <= 1'b1;
                snap_q     <= axis_block_sigs;
                first_id_q <= enc_valid ? enc_idx : '0;
                stamp_q    <= cyc_q;
            end
        end
    end

endmodule

// File: tb/tb_fc_deadlock_watchdog.sv
// tb/tb_fc_deadlock_watchdog.sv - scoreboard bench for fc_deadlock_watchdog with THRESH=16
module tb_fc_deadlock_watchdog;

    localparam int TH = 16;

    logic        clock = 1'b0;
    logic        reset;
    logic [7:0]  axis_block_sigs;
    logic [4:0]  inst_idle_sigs;
    logic [0:0]  inst_block_sigs;
    logic        clear;
    logic        block;
    logic [7:0]  block_axis_snap;
    logic [2:0]  block_first_id;
    logic [31:0] block_cycles;
    logic [1:0]  state_o;

    fc_deadlock_watchdog #(
        .AXIS_N (8),
        .INST_N (5),
        .BLK_N  (1),
        .THRESH (TH)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .clear           (clear),
        .block           (block),
        .block_axis_snap (block_axis_snap),
        .block_first_id  (block_first_id),
        .block_cycles    (block_cycles),
        .state_o         (state_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        blk;
        logic [1:0]  st;
        logic [7:0]  snap;
        logic [2:0]  id;
        logic [31:0] cyc;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model state
    int          m_state;
    int          m_run;
    logic [8:0]  m_prev;
    logic        m_block;
    logic [7:0]  m_snap;
    logic [2:0]  m_id;
    logic [31:0] m_cyc;
    logic [31:0] m_tick;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [2:0] ref_lowest(input logic [7:0] v);
        logic [2:0] r;
        logic       found;
        r = 3'd0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && v[i]) begin
                r = 3'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_run = 0; m_prev = '0; m_block = 1'b0;
        m_snap = '0; m_id = '0; m_cyc = '0; m_tick = '0;
    endtask

    task automatic model_edge(input logic [7:0] a, input logic [4:0] idl, input logic b, input logic clr);
        logic       stall;
        logic [8:0] pat;
        stall = ((a != 0) || b) && (idl != 5'h1F);
        pat   = {b, a};
        if (clr) begin
            m_state = 0; m_run = 0; m_block = 1'b0;
        end else if (m_state == 0) begin
            if (stall) begin m_state = 1; m_run = 1; end
        end else if (m_state == 1) begin
            if (!stall) begin
                m_state = 0; m_run = 0;
            end else if (pat != m_prev) begin
                m_run = 1;
            end else begin
                m_run++;
                if (m_run == TH) begin
                    m_state = 2; m_block = 1'b1; m_snap = a;
                    m_id = ref_lowest(a); m_cyc = m_tick;
                end
            end
        end
        m_prev = pat;
        m_tick = m_tick + 1;
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 64'd1, 64'd0);
            return;
        end
        e = sb_q.pop_front();
        check_eq("block", block, e.blk);
        check_eq("state_o", state_o, e.st);
        check_eq("snap", block_axis_snap, e.snap);
        check_eq("first_id", block_first_id, e.id);
        check_eq("cycles", block_cycles, e.cyc);
    endtask

    task automatic step(input logic [7:0] a, input logic [4:0] idl, input logic b, input logic clr);
        exp_t e;
        axis_block_sigs = a;
        inst_idle_sigs  = idl;
        inst_block_sigs = b;
        clear           = clr;
        model_edge(a, idl, b, clr);
        e = '{blk: m_block, st: 2'(m_state), snap: m_snap, id: m_id, cyc: m_cyc};
        sb_q.push_back(e);
        @(posedge clock);
        #1;
        pop_compare();
    endtask

    task automatic repeat_step(input int n, input logic [7:0] a, input logic b);
        for (int i = 0; i < n; i++) step(a, 5'h00, b, 1'b0);
    endtask

    initial begin
        reset = 1'b1;
        axis_block_sigs = '0; inst_idle_sigs = '0; inst_block_sigs = '0; clear = 1'b0;
        model_reset();
        #12;
        check_eq("rst_block", block, 1'b0);
        check_eq("rst_state", state_o, 2'd0);
        check_eq("rst_snap", block_axis_snap, 8'h00);
        check_eq("rst_cycles", block_cycles, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        repeat_step(3, 8'h00, 1'b0);

        // Basic detection on 8'h04
        repeat_step(15, 8'h04, 1'b0);
        check_eq("pre_det_block", block, 1'b0);
        step(8'h04, 5'h00, 1'b0, 1'b0);
        check_eq("det_block", block, 1'b1);
        check_eq("det_snap", block_axis_snap, 8'h04);
        check_eq("det_id", block_first_id, 3'd2);
        check_eq("det_state", state_o, 2'd2);
        for (int i = 0; i < 4; i++)
            step(8'($urandom), 5'($urandom), 1'($urandom), 1'b0);
        step(8'h00, 5'h00, 1'b0, 1'b1);
        check_eq("clr_block", block, 1'b0);
        check_eq("clr_state", state_o, 2'd0);
        check_eq("clr_snap_kept", block_axis_snap, 8'h04);
        repeat_step(2, 8'h00, 1'b0);

        // Interrupted stall never detects
        repeat_step(15, 8'h04, 1'b0);
        step(8'h00, 5'h00, 1'b0, 1'b0);
        check_eq("gap_state", state_o, 2'd0);
        repeat_step(15, 8'h04, 1'b0);
        check_eq("gap_block", block, 1'b0);
        repeat_step(2, 8'h00, 1'b0);

        // Progress by pattern toggling, then steady 8'h0C
        for (int k = 0; k < 4; k++) repeat_step(10, (k % 2 == 0) ? 8'h04 : 8'h0C, 1'b0);
        repeat_step(10, 8'h04, 1'b0);
        check_eq("toggle_block", block, 1'b0);
        repeat_step(16, 8'h0C, 1'b0);
        check_eq("tog_det_block", block, 1'b1);
        check_eq("tog_det_id", block_first_id, 3'd2);
        check_eq("tog_det_snap", block_axis_snap, 8'h0C);
        step(8'h00, 5'h00, 1'b0, 1'b1);

        // Fully idle kernel is never deadlocked
        for (int i = 0; i < 100; i++) step(8'hFF, 5'h1F, 1'b0, 1'b0);
        check_eq("idle_block", block, 1'b0);
        check_eq("idle_state", state_o, 2'd0);

        // Clear on the detection edge wins
        repeat_step(15, 8'h04, 1'b0);
        step(8'h04, 5'h00, 1'b0, 1'b1);
        check_eq("clr_edge_block", block, 1'b0);
        check_eq("clr_edge_state", state_o, 2'd0);
        repeat_step(3, 8'h04, 1'b0);
        repeat_step(2, 8'h00, 1'b0);

        // Stall caused only by an instance block flag
        repeat_step(16, 8'h00, 1'b1);
        check_eq("inst_det_block", block, 1'b1);
        check_eq("inst_det_snap", block_axis_snap, 8'h00);
        check_eq("inst_det_id", block_first_id, 3'd0);
        step(8'h00, 5'h00, 1'b0, 1'b1);

        // Top bit detection, then async reset mid-WATCH
        repeat_step(16, 8'h80, 1'b0);
        check_eq("msb_det_id", block_first_id, 3'd7);
        step(8'h00, 5'h00, 1'b0, 1'b1);
        repeat_step(10, 8'h04, 1'b0);
        check_eq("watch_state", state_o, 2'd1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_eq("arst_block", block, 1'b0);
        check_eq("arst_state", state_o, 2'd0);
        check_eq("arst_snap", block_axis_snap, 8'h00);
        check_eq("arst_id", block_first_id, 3'd0);
        check_eq("arst_cycles", block_cycles, 32'd0);
        @(posedge clock);
        #1;
        check_eq("arst_hold_state", state_o, 2'd0);
        #3;
        reset = 1'b0;
        repeat_step(15, 8'h04, 1'b0);
        check_eq("post_rst_block", block, 1'b0);
        step(8'h04, 5'h00, 1'b0, 1'b0);
        check_eq("post_rst_det", block, 1'b1);
        check_eq("post_rst_cycles", block_cycles, 32'd15);
        repeat_step(2, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fc_deadlock_watchdog.md
# fc_deadlock_watchdog

- Simulation-side stall watchdog for the FC_CIF_0_1 co-simulation.
- Consumes the flattened per-channel AXI-Stream blocking vector, per-instance idle vector and per-instance block vector that the kernel monitor top assembles from the kernel hierarchy.
- Decides whether the kernel is deadlocked: the same blocking pattern persists, with no progress, for a programmable number of consecutive cycles.
- On that decision it latches a sticky `block` flag plus diagnostic snapshots for the testbench to report.

## Interface
Parameters:
- AXIS_N, 8, number of AXI-Stream blocking signals (bit i = 1 means channel i stalled on TDATA)
- INST_N, 5, number of pipeline-instance idle signals
- BLK_N, 1, number of instance-level block signals
- THRESH, 1024, consecutive identical-stall cycles required to declare deadlock (≥2)

Ports:
- clock  in  1  kernel monitor clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- axis_block_sigs  in  AXIS_N  per-channel stream stall flags
- inst_idle_sigs  in  INST_N  per-instance ap_idle
- inst_block_sigs  in  BLK_N  per-instance block flags
- clear  in  1  synchronous re-arm: returns FSM to IDLE and drops block
- block  out  1  sticky deadlock flag
- block_axis_snap  out  AXIS_N  axis_block_sigs captured at detection
- block_first_id  out  $clog2(AXIS_N)  lowest set index in block_axis_snap
- block_cycles  out  32  free-running cycle stamp captured at detection
- state_o  out  2  current FSM state, for waveform debug

## Operation
- Per-cycle stall condition: stall_now = (|axis_block_sigs | |inst_block_sigs) & ~(&inst_idle_sigs). A fully idle kernel is never a deadlock.
- pattern = {inst_block_sigs, axis_block_sigs}. Register prev_pat each cycle.
- FSM states: IDLE=0, WATCH=1, DEADLOCK=2.
  - IDLE: if stall_now, go to WATCH with cnt=1 and prev_pat=pattern.
  - WATCH: if !stall_now, go to IDLE and set cnt=0. If pattern != prev_pat (progress), stay in WATCH with cnt=1. Otherwise cnt=cnt+1. When the incremented cnt equals THRESH, go to DEADLOCK.
  - DEADLOCK: terminal until clear or reset. Inputs are ignored; outputs are frozen.
- Detection edge: block←1, block_axis_snap←axis_block_sigs, block_cycles←cycle counter, block_first_id←lowest set bit of the snap. If only inst_block_sigs caused the stall, block_first_id=0 and snap=0.
- clear has priority over every transition, including the detection edge in the same cycle: clear wins, so block stays 0.
- cnt width is $clog2(THRESH+1) and saturates. The cycle counter is 32 bits, wraps modulo 2^32, and runs in all states.

## Timing
- Reset values:
  - block=0, block_axis_snap=0, block_first_id=0, block_cycles=0, state_o=IDLE
  - internal cnt=0, prev_pat=0, cycle counter=0
- Reset is asynchronous. Asserting it mid-WATCH or in DEADLOCK clears everything immediately; no detection occurs during reset.
- Latency: with identical stall sampled on edges E1..E_THRESH, block is high after edge E_THRESH. That is THRESH cycles from the first stalled edge.
- A single non-stalled or pattern-changed cycle restarts the count. THRESH-1 stalled cycles, then 1 progress cycle, then THRESH-1 stalled cycles never asserts block.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `fc_dlmon_pkg`:
  - state enum dlmon_state_t {IDLE, WATCH, DEADLOCK}
  - CYC_W=32
  - a lowest-set-bit function for widths up to 32
- Sub-module `fc_dlmon_prio_enc`: parameterised width, combinational lowest-set-bit encoder with a `valid` output. It feeds the block_first_id capture register.
- Core RTL (FSM, counters, capture regs) is roughly 150–200 lines.

## Test plan
- THRESH=16, axis_block_sigs=8'h04 held, idle=0 → block rises after edge 16, snap=8'h04, first_id=2, state_o=2.
- Same stall held for 15 cycles, then 1 cycle of 8'h00, then 15 more → block stays 0 and state_o returns to IDLE once.
- axis_block_sigs toggles between 8'h04 and 8'h0C every 10 cycles with THRESH=16 → never deadlocks. Then hold 8'h0C → block after 16 cycles, first_id=2.
- All inst_idle_sigs=5'h1F with axis_block_sigs=8'hFF for 100 cycles → block=0, state_o=IDLE.
- Deadlock at cycle N, then clear pulsed 1 cycle → block=0 and IDLE next cycle, snapshots retained. Clear asserted on the detection edge → block never rises.
- Reset asserted asynchronously mid-WATCH (cnt=10) → all outputs 0 immediately. After release, a fresh 16-cycle stall is needed to detect.
